mc_controller_ws: RTL and testbench

//  Next-gen multicycle controller for the accumulator CPU. Same datapath strobes as today's FSM, plus:

---
 rtl/mc_controller_ws.sv | 212 +++++++++++++++++++++
 tb/tb_mc_controller_ws.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_controller_ws.sv
// mc_controller_ws
// Multicycle controller for the accumulator CPU. It steps through fetch,
// decode, memory and write-back states one instruction at a time.
// Memory states hold their request until MemReady is high. A stall that goes
// on too long drops the controller into a sticky bus-error state. HALT is
// left by a one-cycle Resume pulse.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   OPCode            opcode from IR, stable from ID1 until the next IF1
//   ZFlag             datapath zero flag, used by jump-if-zero
//   MemReady          memory completes the current access this cycle
//   Resume            one-cycle pulse that leaves HALT
//   Halt, BusErr      status: in HALT / in BUSERR
//   MemReq, MemRead, MemWrite, IOD     memory handshake and address select
//   PCWrite, PcSel, Jmp                PC control
//   LIR, LTR, LdDI                     IR / operand / direct-immediate loads
//   RegSel, BSel, WriteSel, RegWrite   register file and ALU operand control
//   LdC, LdN, LdZ                      flag load enables
//   AluOp (00 add, 01 and, 10 or), RegOrMem (00 mem, 01 ALU, 10 reg)
module mc_controller_ws #(
    parameter int OPC_W    = 4,
    parameter int MAX_WAIT = 15,
    parameter bit HAS_JZ   = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [OPC_W-1:0] OPCode,
    input  logic             ZFlag,
    input  logic             MemReady,
    input  logic             Resume,
    output logic             Halt,
    output logic             BusErr,
    output logic             MemReq,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IOD,
    output logic             PCWrite,
    output logic             PcSel,
    output logic             Jmp,
    output logic             LIR,
    output logic             LTR,
    output logic             LdDI,
    output logic             RegSel,
    output logic             BSel,
    output logic             WriteSel,
    output logic             RegWrite,
    output logic             LdC,
    output logic             LdN,
    output logic             LdZ,
    output logic [1:0]       AluOp,
    output logic [1:0]       RegOrMem
);

    typedef enum logic [4:0] {
        S_IF1 = 5'd0, S_ID1, S_IF2, S_ID2, S_LDA1, S_LDA2, S_STA1, S_STA2,
        S_ADNA, S_CALADA, S_CALANA, S_SAVE1, S_DI, S_JMP, S_ACCDEC, S_MVR,
        S_ADR, S_ANR, S_ORR, S_SAVE2, S_HALT, S_BUSERR
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t     state_r;
    logic [7:0] wait_r;
    logic [3:0] op_s;
    logic       upper_set_s;
    logic       jz_s;
    logic       taken_s;
    logic       is_mem_s;
    logic       timeout_s;

    assign op_s = OPCode[3:0];

    // Any set opcode bit above the base nibble makes the instruction illegal.
    generate
        if (OPC_W > 4) begin : g_upper
            assign upper_set_s = |OPCode[OPC_W-1:4];
        end else begin : g_no_upper
            assign upper_set_s = 1'b0;
        end
    endgenerate

    assign jz_s      = HAS_JZ && (op_s == 4'b1101);
    assign taken_s   = !jz_s || ZFlag;
    assign is_mem_s  = (state_r == S_IF1) || (state_r == S_IF2) || (state_r == S_LDA1) ||
                       (state_r == S_STA2) || (state_r == S_ADNA);
    // A completing access (MemReady=1) always beats the timeout.
    assign timeout_s = !MemReady && (wait_r == WAIT_LAST);

    // Successor of a memory state: advance on ready, give up on timeout, else hold.
    function automatic state_t mem_next(input state_t cur, input state_t tgt,
                                        input logic ready, input logic tmo);
        if (ready) begin
            mem_next = tgt;
        end else if (tmo) begin
            mem_next = S_BUSERR;
        end else begin
            mem_next = cur;
        end
    endfunction

    // State register and wait-state counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IF1;
            wait_r  <= 8'd0;
        end else begin
            // Counts only consecutive stalled cycles, so it reads 0 on entry to every memory state.
            if (is_mem_s && !MemReady && !timeout_s) begin
                wait_r <= wait_r + 8'd1;
            end else begin
                wait_r <= 8'd0;
            end
            case (state_r)
                S_IF1:    state_r <= mem_next(S_IF1, S_ID1, MemReady, timeout_s);
                S_ID1: begin
                    if (upper_set_s) begin
                        state_r <= S_HALT;
                    end else begin
                        casez (op_s)
                            4'b0???: state_r <= S_IF2;
                            4'b110?: state_r <= S_IF2;
                            4'b111?: state_r <= S_DI;
                            4'b10??: state_r <= S_ACCDEC;
                            default: state_r <= S_HALT;
                        endcase
                    end
                end
                S_IF2:    state_r <= mem_next(S_IF2, S_ID2, MemReady, timeout_s);
                S_ID2: begin
                    casez (op_s[3:1])
                        3'b000:  state_r <= S_LDA1;
                        3'b001:  state_r <= S_STA1;
                        3'b01?:  state_r <= S_ADNA;
                        3'b110:  state_r <= S_JMP;
                        default: state_r <= S_IF1;
                    endcase
                end
                S_LDA1:   state_r <= mem_next(S_LDA1, S_LDA2, MemReady, timeout_s);
                S_LDA2:   state_r <= S_IF1;
                S_STA1:   state_r <= S_STA2;
                S_STA2:   state_r <= mem_next(S_STA2, S_IF1, MemReady, timeout_s);
                S_ADNA:   state_r <= mem_next(S_ADNA, op_s[1] ? S_CALANA : S_CALADA,
                                              MemReady, timeout_s);
                S_CALADA: state_r <= S_SAVE1;
                S_CALANA: state_r <= S_SAVE1;
                S_SAVE1:  state_r <= S_IF1;
                S_DI:     state_r <= S_IF1;
                S_JMP:    state_r <= S_IF1;
                S_ACCDEC: begin
                    case (op_s[1:0])
                        2'b00:   state_r <= S_MVR;
                        2'b01:   state_r <= S_ADR;
                        2'b10:   state_r <= S_ANR;
                        default: state_r <= S_ORR;
                    endcase
                end
                S_MVR:    state_r <= S_IF1;
                S_ADR:    state_r <= S_SAVE2;
                S_ANR:    state_r <= S_SAVE2;
                S_ORR:    state_r <= S_SAVE2;
                S_SAVE2:  state_r <= S_IF1;
                S_HALT:   state_r <= Resume ? S_IF1 : S_HALT;
                S_BUSERR: state_r <= S_BUSERR;
                default:  state_r <= S_IF1;
            endcase
        end
    end

    // Output decode: Moore on state, commit strobes qualified by MemReady, all low while in reset.
    always_comb begin
        Halt = 1'b0;     BusErr = 1'b0;   MemReq = 1'b0;   MemRead = 1'b0;
        MemWrite = 1'b0; IOD = 1'b0;      PCWrite = 1'b0;  PcSel = 1'b0;
        Jmp = 1'b0;      LIR = 1'b0;      LTR = 1'b0;      LdDI = 1'b0;
        RegSel = 1'b0;   BSel = 1'b0;     WriteSel = 1'b0; RegWrite = 1'b0;
        LdC = 1'b0;      LdN = 1'b0;      LdZ = 1'b0;
        AluOp = 2'b00;   RegOrMem = 2'b00;
        if (rst_n) begin
            case (state_r)
                S_IF1:    begin MemReq = 1'b1; MemRead = 1'b1; LIR = MemReady; PCWrite = MemReady; end
                S_IF2:    begin MemReq = 1'b1; MemRead = 1'b1; LTR = MemReady; PCWrite = MemReady; end
                S_LDA1:   begin MemReq = 1'b1; MemRead = 1'b1; IOD = 1'b1; end
                // Memory data was captured on LDA1's completing cycle.
                S_LDA2:   begin RegWrite = 1'b1; RegOrMem = 2'b00; end
                S_STA2:   begin MemReq = 1'b1; MemWrite = 1'b1; IOD = 1'b1; end
                S_ADNA:   begin MemReq = 1'b1; MemRead = 1'b1; IOD = 1'b1; end
                S_CALADA: begin BSel = 1'b1; AluOp = 2'b00; LdC = 1'b1; LdN = 1'b1; LdZ = 1'b1; end
                S_CALANA: begin BSel = 1'b1; AluOp = 2'b01; LdN = 1'b1; LdZ = 1'b1; end
                S_SAVE1:  begin RegWrite = 1'b1; RegOrMem = 2'b01; end
                S_DI:     begin LdDI = 1'b1; end
                S_JMP: begin
                    if (taken_s) begin
                        Jmp = 1'b1; PcSel = 1'b1; PCWrite = 1'b1;
                    end else begin
                        Jmp = 1'b0; PcSel = 1'b0; PCWrite = 1'b0;
                    end
                end
                S_MVR:    begin RegWrite = 1'b1; WriteSel = 1'b1; RegOrMem = 2'b10; end
                S_ADR:    begin RegSel = 1'b1; AluOp = 2'b00; LdC = 1'b1; LdN = 1'b1; LdZ = 1'b1; end
                S_ANR:    begin RegSel = 1'b1; AluOp = 2'b01; LdN = 1'b1; LdZ = 1'b1; end
                S_ORR:    begin RegSel = 1'b1; AluOp = 2'b10; LdN = 1'b1; LdZ = 1'b1; end
                S_SAVE2:  begin RegWrite = 1'b1; WriteSel = 1'b1; RegOrMem = 2'b01; end
                S_HALT:   begin Halt = 1'b1; end
                S_BUSERR: begin BusErr = 1'b1; end
                default:  begin Halt = 1'b0; end
            endcase
        end else begin
            Halt = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_controller_ws.sv
// Bench for mc_controller_ws. The reference is a queue of per-cycle steps
// that is expanded from each fetched opcode. Memory steps repeat while
// MemReady is low, and a stall that runs too long switches the reference to
// bus error. Every cycle, the full output vector is compared with the
// reference. Directed sequences also pin the reference with literal values.
module tb_mc_controller_ws;

    localparam int MAXW = 4;

    localparam logic [22:0] O_HALT = 23'h400000, O_BERR = 23'h200000, O_MREQ = 23'h100000,
                            O_MRD  = 23'h080000, O_MWR  = 23'h040000, O_IOD  = 23'h020000,
                            O_PCW  = 23'h010000, O_PCS  = 23'h008000, O_JMP  = 23'h004000,
                            O_LIR  = 23'h002000, O_LTR  = 23'h001000, O_LDDI = 23'h000800,
                            O_RSEL = 23'h000400, O_BSEL = 23'h000200, O_WSEL = 23'h000100,
                            O_RW   = 23'h000080, O_LDC  = 23'h000040, O_LDN  = 23'h000020,
                            O_LDZ  = 23'h000010, O_AND  = 23'h000004, O_OR   = 23'h000008,
                            O_RALU = 23'h000001, O_RREG = 23'h000002, O_NONE = 23'h000000;

    localparam int K_OTHER = 0, K_FETCH = 1, K_LDA1 = 2, K_STA2 = 3, K_JMP = 4, K_HALT = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [7:0] OPCode = 8'h00;
    logic ZFlag = 1'b0, MemReady = 1'b0, Resume = 1'b0;
    logic Halt, BusErr, MemReq, MemRead, MemWrite, IOD, PCWrite, PcSel, Jmp, LIR, LTR, LdDI;
    logic RegSel, BSel, WriteSel, RegWrite, LdC, LdN, LdZ;
    logic [1:0] AluOp, RegOrMem;
    logic [22:0] act_s;

    always #5 clk = ~clk;

    mc_controller_ws #(.OPC_W(8), .MAX_WAIT(MAXW), .HAS_JZ(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .OPCode(OPCode), .ZFlag(ZFlag), .MemReady(MemReady),
        .Resume(Resume), .Halt(Halt), .BusErr(BusErr), .MemReq(MemReq), .MemRead(MemRead),
        .MemWrite(MemWrite), .IOD(IOD), .PCWrite(PCWrite), .PcSel(PcSel), .Jmp(Jmp),
        .LIR(LIR), .LTR(LTR), .LdDI(LdDI), .RegSel(RegSel), .BSel(BSel), .WriteSel(WriteSel),
        .RegWrite(RegWrite), .LdC(LdC), .LdN(LdN), .LdZ(LdZ), .AluOp(AluOp), .RegOrMem(RegOrMem)
    );

    assign act_s = {Halt, BusErr, MemReq, MemRead, MemWrite, IOD, PCWrite, PcSel, Jmp, LIR, LTR,
                    LdDI, RegSel, BSel, WriteSel, RegWrite, LdC, LdN, LdZ, AluOp, RegOrMem};

    typedef struct {
        logic [22:0] base;
        logic [22:0] gated;
        bit          mem;
        bit          jmp;
        bit          jz;
        int          kind;
    } step_t;

    step_t plan[$];
    int    wcnt = 0;
    bit    buserr = 1'b0;
    int    checks = 0;
    int    errors = 0;
    logic [7:0] cur_opc = 8'h00;
    logic [22:0] act;

    task automatic chk(input string name, input logic [22:0] a, input logic [22:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, a, e, $time);
        end
    endtask

    task automatic add(input logic [22:0] b, input logic [22:0] g, input bit m, input int k,
                       input bit jm, input bit jz);
        step_t s;
        s.base = b; s.gated = g; s.mem = m; s.kind = k; s.jmp = jm; s.jz = jz;
        plan.push_back(s);
    endtask

    task automatic add_fetch();
        add(O_MREQ | O_MRD, O_LIR | O_PCW, 1'b1, K_FETCH, 1'b0, 1'b0);
    endtask

    // Everything an instruction does after its first word has been fetched.
    task automatic build(input logic [7:0] op);
        logic [3:0] lo;
        lo = op[3:0];
        add(O_NONE, O_NONE, 1'b0, K_OTHER, 1'b0, 1'b0);
        if (op[7:4] != 4'h0) begin
            add(O_HALT, O_NONE, 1'b0, K_HALT, 1'b0, 1'b0);
        end else if (lo[3] == 1'b0 || lo[3:1] == 3'b110) begin
            add(O_MREQ | O_MRD, O_LTR | O_PCW, 1'b1, K_OTHER, 1'b0, 1'b0);
            add(O_NONE, O_NONE, 1'b0, K_OTHER, 1'b0, 1'b0);
            case (lo[3:1])
                3'b000: begin
                    add(O_MREQ | O_MRD | O_IOD, O_NONE, 1'b1, K_LDA1, 1'b0, 1'b0);
                    add(O_RW, O_NONE, 1'b0, K_OTHER, 1'b0, 1'b0);
                end
                3'b001: begin
                    add(O_NONE, O_NONE, 1'b0, K_OTHER, 1'b0, 1'b0);
                    add(O_MREQ | O_MWR | O_IOD, O_NONE, 1'b1, K_STA2, 1'b0, 1'b0);
                end
                3'b010: begin
                    add(O_MREQ | O_MRD | O_IOD, O_NONE, 1'b1, K_OTHER, 1'b0, 1'b0);
                    add(O_BSEL | O_LDC | O_LDN | O_LDZ, O_NONE, 1'b0, K_OTHER, 1'b0, 1'b0);
                    add(O_RW | O_RALU, O_NONE, 1'b0, K_OTHER, 1'b0, 1'b0);
                end
                3'b011: begin
                    add(O_MREQ | O_MRD | O_IOD, O_NONE, 1'b1, K_OTHER, 1'b0, 1'b0);
                    add(O_BSEL | O_LDN | O_LDZ | O_AND, O_NONE, 1'b0, K_OTHER, 1'b0, 1'b0);
                    add(O_RW | O_RALU, O_NONE, 1'b0, K_OTHER, 1'b0, 1'b0);
                end
                default: add(O_NONE, O_NONE, 1'b0, K_JMP, 1'b1, lo[0]);
            endcase
        end else if (lo[3:1] == 3'b111) begin
            add(O_LDDI, O_NONE, 1'b0, K_OTHER, 1'b0, 1'b0);
        end else begin
            add(O_NONE, O_NONE, 1'b0, K_OTHER, 1'b0, 1'b0);
            case (lo[1:0])
                2'b00: add(O_RW | O_WSEL | O_RREG, O_NONE, 1'b0, K_OTHER, 1'b0, 1'b0);
                2'b01: add(O_RSEL | O_LDC | O_LDN | O_LDZ, O_NONE, 1'b0, K_OTHER, 1'b0, 1'b0);
                2'b10: add(O_RSEL | O_LDN | O_LDZ | O_AND, O_NONE, 1'b0, K_OTHER, 1'b0, 1'b0);
                default: add(O_RSEL | O_LDN | O_LDZ | O_OR, O_NONE, 1'b0, K_OTHER, 1'b0, 1'b0);
            endcase
            if (lo[1:0] != 2'b00) add(O_RW | O_WSEL | O_RALU, O_NONE, 1'b0, K_OTHER, 1'b0, 1'b0);
        end
    endtask

    function automatic logic [22:0] model_exp(input logic mr, input logic z);
        logic [22:0] e;
        if (buserr) return O_BERR;
        e = plan[0].base | (mr ? plan[0].gated : O_NONE);
        if (plan[0].jmp && (!plan[0].jz || z)) e = e | O_JMP | O_PCS | O_PCW;
        return e;
    endfunction

    task automatic model_step(input logic mr, input logic res);
        step_t s;
        if (!buserr) begin
            s = plan[0];
            if (s.kind == K_HALT) begin
                if (res) void'(plan.pop_front());
            end else if (s.mem) begin
                if (mr) begin
                    void'(plan.pop_front());
                    wcnt = 0;
                    if (s.kind == K_FETCH) build(cur_opc);
                end else if (wcnt == MAXW - 1) begin
                    buserr = 1'b1;
                end else begin
                    wcnt++;
                end
            end else begin
                void'(plan.pop_front());
            end
            if (plan.size() == 0) add_fetch();
        end
    endtask

    task automatic model_reset();
        plan.delete();
        add_fetch();
        wcnt = 0;
        buserr = 1'b0;
    endtask

    // One clock: drive at the falling edge, compare shortly after, then advance the reference.
    task automatic cyc(input logic mr, input logic z, input logic res);
        @(negedge clk);
        MemReady = mr; ZFlag = z; Resume = res; OPCode = cur_opc;
        #1;
        act = act_s;
        chk("cycle", act, model_exp(mr, z));
        model_step(mr, res);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("reset_low", act_s, O_NONE);
        @(posedge clk);
        #2 rst_n = 1'b1;
        model_reset();
    endtask

    task automatic run_to(input int k, input int maxc);
        bit found;
        found = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            if (!buserr && plan[0].kind == k) begin
                found = 1'b1;
                break;
            end
            cyc(1'b1, 1'b0, 1'b0);
        end
        if (!found && !buserr && plan[0].kind == k) found = 1'b1;
        chk("reach_step", {22'd0, found}, 23'd1);
    endtask

    initial begin
        logic [5:0] rw;
        int nreq, nlir, berr_cycles;
        logic mr, z, res;

        repeat (2) @(posedge clk);
        #1 chk("in_reset", act_s, O_NONE);
        #1 rst_n = 1'b1;
        model_reset();

        // LDA with memory always ready: six cycles, write-back only in the last.
        cur_opc = 8'h00;
        rw = 6'd0;
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 1'b0, 1'b0);
            if (i == 0) chk("if1_outputs", act, 23'h192000);
            rw[i] = act[7];
        end
        chk("lda_regwrite", {17'd0, rw}, {17'd0, 6'b100000});

        // IF1 stalled three cycles.
        cur_opc = 8'h06;
        nreq = 0; nlir = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(i == 3, 1'b0, 1'b0);
            nreq += int'(act[20]);
            nlir += int'(act[13]);
        end
        chk("if1_stall_memreq", 23'(nreq), 23'd4);
        chk("if1_stall_lir", 23'(nlir), 23'd1);
        run_to(K_FETCH, 20);

        // MemReady stuck low in LDA1 -> bus error after MAXW stalls, sticky.
        cur_opc = 8'h01;
        run_to(K_LDA1, 20);
        for (int i = 0; i < MAXW; i++) cyc(1'b0, 1'b0, 1'b0);
        chk("lda1_still_waiting", {22'd0, act[21]}, 23'd0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("buserr_set", act, 23'h200000);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 1'b1);
            chk("buserr_sticky", act, 23'h200000);
        end
        do_reset();

        // Jump-if-zero not taken, then taken; unconditional jump taken.
        cur_opc = 8'h0D;
        run_to(K_JMP, 20);
        cyc(1'b1, 1'b0, 1'b0);
        chk("jz_not_taken", {20'd0, act[16:14]}, 23'd0);
        run_to(K_JMP, 20);
        cyc(1'b1, 1'b1, 1'b0);
        chk("jz_taken", {20'd0, act[16:14]}, 23'd7);
        cur_opc = 8'h0C;
        run_to(K_JMP, 20);
        cyc(1'b1, 1'b0, 1'b0);
        chk("jmp_taken", {20'd0, act[16:14]}, 23'd7);

        // Illegal wide opcode halts; Resume returns to fetch; Resume in IF1 is ignored.
        run_to(K_FETCH, 20);
        cur_opc = 8'hF0;
        run_to(K_HALT, 20);
        cyc(1'b1, 1'b0, 1'b0);
        chk("halt_set", act, 23'h400000);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1);
        chk("halt_on_resume_cycle", act, 23'h400000);
        cur_opc = 8'h04;
        cyc(1'b0, 1'b0, 1'b1);
        chk("resume_to_if1", act, 23'h180000);
        cyc(1'b1, 1'b0, 1'b1);
        chk("resume_in_if1_ignored", act, 23'h192000);
        run_to(K_FETCH, 20);

        // Reset in the middle of a stalled store.
        cur_opc = 8'h03;
        run_to(K_STA2, 20);
        cyc(1'b0, 1'b0, 1'b0);
        chk("sta2_write", {22'd0, act[18]}, 23'd1);
        do_reset();
        cyc(1'b1, 1'b0, 1'b0);
        chk("restart_if1", act, 23'h192000);

        // Randomized traffic.
        berr_cycles = 0;
        for (int n = 0; n < 3000; n++) begin
            if (buserr) begin
                berr_cycles++;
                if (berr_cycles > 3) begin
                    do_reset();
                    berr_cycles = 0;
                end
            end
            if (!buserr && plan[0].kind == K_FETCH) begin
                if ($urandom_range(7, 0) == 0)
                    cur_opc = {4'($urandom_range(15, 1)), 4'($urandom_range(15, 0))};
                else
                    cur_opc = {4'h0, 4'($urandom_range(15, 0))};
            end
            mr  = ($urandom_range(3, 0) != 0);
            z   = 1'($urandom_range(1, 0));
            res = ($urandom_range(4, 0) == 0);
            cyc(mr, z, res);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
